// File: rtl/cdc_pulse_rx.sv
// Receive side of a toggle-based pulse synchronizer: turns each req_tgl level change
// into a pending event, returns ack_tgl to the sender and counts undelivered events.
module cdc_pulse_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_tgl,
    output logic             ack_tgl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] pend_cnt,
    output logic             ovf,
    input  logic             ovf_clr
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   req_d_q, req_d_d;
    logic [CNT_W-1:0]       pend_cnt_q, pend_cnt_d;
    logic                   ovf_q, ovf_d;
    logic                   evt, consume, drop;

    // Saturating pending-count update; a simultaneous event and consume cancel out.
    function automatic logic [CNT_W-1:0] next_cnt(
        input logic [CNT_W-1:0] cnt,
        input logic             ev,
        input logic             cons
    );
        logic [CNT_W-1:0] res;
        res = cnt;
        if (ev && !cons && (cnt != CNT_MAX)) begin
            res = cnt + CNT_W'(1);
        end else if (cons && !ev) begin
            res = cnt - CNT_W'(1);
        end
        return res;
    endfunction

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], req_tgl};
        req_d_d    = sync_q[SYNC_STAGES-1];
        evt        = sync_q[SYNC_STAGES-1] ^ req_d_q;
        consume    = out_valid && out_ready;
        drop       = evt && !consume && (pend_cnt_q == CNT_MAX);
        pend_cnt_d = next_cnt(pend_cnt_q, evt, consume);
        ovf_d      = drop || (ovf_q && !ovf_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '0;
            req_d_q    <= 1'b0;
            pend_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            req_d_q    <= req_d_d;
            pend_cnt_q <= pend_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    // ack follows req_d so it toggles on the edge that counts the event, dropped or not.
    assign ack_tgl   = req_d_q;
    assign out_valid = (pend_cnt_q != '0);
    assign pend_cnt  = pend_cnt_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_cdc_pulse_rx.sv
// Directed bench for cdc_pulse_rx: one main instance (SYNC_STAGES=2, CNT_W=2) plus
// SYNC_STAGES=3 and 4 instances sharing its inputs for the latency sweep.
module tb_cdc_pulse_rx;

    logic clk = 1'b0;
    logic rst, req_tgl, out_ready, ovf_clr;

    logic       ack2, vld2, ovf2;
    logic [1:0] cnt2;
    logic       ack3, vld3, ovf3;
    logic [1:0] cnt3;
    logic       ack4, vld4, ovf4;
    logic [1:0] cnt4;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    cdc_pulse_rx #(.SYNC_STAGES(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .req_tgl(req_tgl), .ack_tgl(ack2), .out_valid(vld2),
        .out_ready(out_ready), .pend_cnt(cnt2), .ovf(ovf2), .ovf_clr(ovf_clr)
    );
    cdc_pulse_rx #(.SYNC_STAGES(3), .CNT_W(2)) dut3 (
        .clk(clk), .rst(rst), .req_tgl(req_tgl), .ack_tgl(ack3), .out_valid(vld3),
        .out_ready(out_ready), .pend_cnt(cnt3), .ovf(ovf3), .ovf_clr(ovf_clr)
    );
    cdc_pulse_rx #(.SYNC_STAGES(4), .CNT_W(2)) dut4 (
        .clk(clk), .rst(rst), .req_tgl(req_tgl), .ack_tgl(ack4), .out_valid(vld4),
        .out_ready(out_ready), .pend_cnt(cnt4), .ovf(ovf4), .ovf_clr(ovf_clr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; req_tgl = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
        step(); step(); step();
        chk("rst_cnt", {6'd0, cnt2}, 8'd0);
        chk("rst_vld", {7'd0, vld2}, 8'd0);
        chk("rst_ack", {7'd0, ack2}, 8'd0);
        chk("rst_ovf", {7'd0, ovf2}, 8'd0);

        // Single event: new level sampled at E0, counted at E2 (S=2), E3 (S=3), E4 (S=4)
        rst = 1'b0; req_tgl = 1'b1;
        step();
        chk("lat_e0_cnt", {6'd0, cnt2}, 8'd0);
        step();
        chk("lat_e1_cnt", {6'd0, cnt2}, 8'd0);
        chk("lat_e1_ack", {7'd0, ack2}, 8'd0);
        step();
        chk("lat_e2_cnt", {6'd0, cnt2}, 8'd1);
        chk("lat_e2_vld", {7'd0, vld2}, 8'd1);
        chk("lat_e2_ack", {7'd0, ack2}, 8'd1);
        chk("s3_e2_cnt",  {6'd0, cnt3}, 8'd0);
        step();
        chk("lat_e3_once", {6'd0, cnt2}, 8'd1);
        chk("s3_e3_cnt",   {6'd0, cnt3}, 8'd1);
        chk("s3_e3_ack",   {7'd0, ack3}, 8'd1);
        chk("s4_e3_cnt",   {6'd0, cnt4}, 8'd0);
        step();
        chk("s4_e4_cnt", {6'd0, cnt4}, 8'd1);
        chk("s4_e4_vld", {7'd0, vld4}, 8'd1);
        chk("s2_e4_cnt", {6'd0, cnt2}, 8'd1);

        // Second event brings the count to 2, then drain with out_ready held high
        req_tgl = 1'b0;
        step(); step(); step();
        chk("two_cnt", {6'd0, cnt2}, 8'd2);
        out_ready = 1'b1;
        step();
        chk("drain_1", {6'd0, cnt2}, 8'd1);
        step();
        chk("drain_0", {6'd0, cnt2}, 8'd0);
        chk("drain_vld", {7'd0, vld2}, 8'd0);
        step();
        chk("no_underflow", {6'd0, cnt2}, 8'd0);
        out_ready = 1'b0;

        // Simultaneous event and consume with pend_cnt=1
        req_tgl = 1'b1;
        step(); step(); step();
        chk("sim_pre", {6'd0, cnt2}, 8'd1);
        req_tgl = 1'b0;
        step(); step();
        out_ready = 1'b1;
        step();
        chk("sim_cnt", {6'd0, cnt2}, 8'd1);
        chk("sim_vld", {7'd0, vld2}, 8'd1);
        out_ready = 1'b0;
        step();
        chk("sim_hold", {6'd0, cnt2}, 8'd1);

        // Empty the counter, then four well-spaced toggles with out_ready=0
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("ovf_pre", {6'd0, cnt2}, 8'd0);
        req_tgl = 1'b1; step(); step(); step();
        chk("ov_t1", {6'd0, cnt2}, 8'd1);
        req_tgl = 1'b0; step(); step(); step();
        chk("ov_t2", {6'd0, cnt2}, 8'd2);
        req_tgl = 1'b1; step(); step(); step();
        chk("ov_t3_cnt", {6'd0, cnt2}, 8'd3);
        chk("ov_t3_ovf", {7'd0, ovf2}, 8'd0);
        chk("ov_t3_ack", {7'd0, ack2}, 8'd1);
        req_tgl = 1'b0; step(); step(); step();
        chk("ov_t4_cnt", {6'd0, cnt2}, 8'd3);
        chk("ov_t4_ovf", {7'd0, ovf2}, 8'd1);
        chk("ov_t4_ack", {7'd0, ack2}, 8'd0);
        step();
        chk("ov_sticky", {7'd0, ovf2}, 8'd1);

        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_clr", {7'd0, ovf2}, 8'd0);

        // Event at saturation together with consume: no overflow, count unchanged
        req_tgl = 1'b1;
        step(); step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("satcons_cnt", {6'd0, cnt2}, 8'd3);
        chk("satcons_ovf", {7'd0, ovf2}, 8'd0);
        chk("satcons_ack", {7'd0, ack2}, 8'd1);

        // New overflow on the same edge as ovf_clr: set wins
        req_tgl = 1'b0;
        step(); step();
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("clr_vs_set", {7'd0, ovf2}, 8'd1);
        chk("clr_vs_set_cnt", {6'd0, cnt2}, 8'd3);
        chk("clr_vs_set_ack", {7'd0, ack2}, 8'd0);

        // Reset mid-operation with pend_cnt=2 and req_tgl=1 held through reset
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("mid_pre", {6'd0, cnt2}, 8'd2);
        req_tgl = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_cnt", {6'd0, cnt2}, 8'd0);
        chk("mid_vld", {7'd0, vld2}, 8'd0);
        chk("mid_ovf", {7'd0, ovf2}, 8'd0);
        chk("mid_ack", {7'd0, ack2}, 8'd0);
        step(); step();
        chk("mid_e1_cnt", {6'd0, cnt2}, 8'd0);
        step();
        chk("mid_recount", {6'd0, cnt2}, 8'd1);
        chk("mid_ack1", {7'd0, ack2}, 8'd1);
        step(); step();
        chk("mid_once", {6'd0, cnt2}, 8'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
